// File: rtl/serdes_link_pkg.sv
// Shared definitions for the serdes packet link: header layout, FSM state
// encoding and the maximum transaction length for a given count-field width.
package serdes_link_pkg;

  // Header word bit positions
  localparam int VALID_BIT = 0;
  localparam int DEST_BIT  = 1;
  localparam int CNT_LSB   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // The count field carries LEN+1 (header included) and must not wrap,
  // so the largest data length is 2**bits - 2.
  function automatic int max_len(input int n_pkts_bits);
    return (1 << n_pkts_bits) - 2;
  endfunction

endpackage

// File: rtl/packet_link_arbiter_rr_arbiter.sv
// Round-robin picker: first requesting index at or after ptr, wrapping.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter
  import serdes_link_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  // Scan NUM_SRC candidates starting at ptr; keep the first hit.
  always_comb begin
    int idx;
    logic [IDX_W-1:0] sel;
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      sel = IDX_W'(idx);
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        winner     = sel;
      end
    end
  end

endmodule

// File: rtl/packet_link_arbiter.sv
// Shares one outbound packet link among NUM_SRC sources. Each transaction is
// a header word, LEN data words popped back-to-back from the owner, and
// GAP_CYCLES idle words. packet_o is registered: the register is loaded one
// cycle ahead of the state that names what packet_o currently shows, so the
// header appears the cycle after the winning request is seen.
module packet_link_arbiter
  import serdes_link_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int PACKET_WIDTH = 16,
  parameter int N_PKTS_BITS  = 5,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                            clk_packet,
  input  logic                            reset,
  input  logic [NUM_SRC-1:0]              src_req_i,
  input  logic [NUM_SRC*N_PKTS_BITS-1:0]  src_len_i,
  input  logic [NUM_SRC-1:0]              src_dest_i,
  input  logic [NUM_SRC*PACKET_WIDTH-1:0] src_data_i,
  output logic [NUM_SRC-1:0]              src_pop_o,
  input  logic                            link_af_i,
  output logic [PACKET_WIDTH-1:0]         packet_o,
  output logic [NUM_SRC-1:0]              grant_o,
  output logic                            busy_o,
  output logic                            err_o
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [N_PKTS_BITS-1:0] MAX_LEN_V = N_PKTS_BITS'(max_len(N_PKTS_BITS));

  logic [N_PKTS_BITS-1:0]  len_arr  [NUM_SRC];
  logic [PACKET_WIDTH-1:0] data_arr [NUM_SRC];
  logic [NUM_SRC-1:0]      len_ok;
  logic [NUM_SRC-1:0]      eligible;
  logic                    malformed;

  logic [NUM_SRC-1:0]      arb_grant;
  logic [IDX_W-1:0]        arb_winner;
  logic                    arb_any;
  logic [PACKET_WIDTH-1:0] header;

  state_t                  state_reg,  state_next;
  logic [N_PKTS_BITS-1:0]  cnt_reg,    cnt_next;
  logic [GAP_W-1:0]        gap_reg,    gap_next;
  logic [NUM_SRC-1:0]      grant_reg,  grant_next;
  logic [IDX_W-1:0]        idx_reg,    idx_next;
  logic [IDX_W-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [PACKET_WIDTH-1:0] packet_reg, packet_next;
  logic                    err_reg,    err_next;

  // Unpack per-source slices; a request with LEN outside 1..MAX_LEN is masked.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign len_arr[gi]  = src_len_i[gi*N_PKTS_BITS +: N_PKTS_BITS];
    assign data_arr[gi] = src_data_i[gi*PACKET_WIDTH +: PACKET_WIDTH];
    assign len_ok[gi]   = (len_arr[gi] != '0) && (len_arr[gi] <= MAX_LEN_V);
  end

  assign eligible  = src_req_i & len_ok;
  assign malformed = |(src_req_i & ~len_ok);

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req    (eligible),
    .ptr    (rr_ptr_reg),
    .grant  (arb_grant),
    .winner (arb_winner),
    .any    (arb_any)
  );

  // Header for the current arbitration winner: valid, dest, LEN+1.
  always_comb begin
    header                              = '0;
    header[VALID_BIT]                   = 1'b1;
    header[DEST_BIT]                    = src_dest_i[arb_winner];
    header[CNT_LSB +: N_PKTS_BITS]      = len_arr[arb_winner] + N_PKTS_BITS'(1);
  end

  // Next-state, next link word and combinational pop for the owning source.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    gap_next    = gap_reg;
    grant_next  = grant_reg;
    idx_next    = idx_reg;
    rr_ptr_next = rr_ptr_reg;
    packet_next = '0;
    err_next    = err_reg;
    src_pop_o   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (malformed) err_next = 1'b1;
        if (arb_any && !link_af_i) begin
          state_next  = ST_HEADER;
          packet_next = header;
          grant_next  = arb_grant;
          idx_next    = arb_winner;
          cnt_next    = len_arr[arb_winner];
          rr_ptr_next = (arb_winner == IDX_W'(NUM_SRC - 1)) ? '0
                                                             : arb_winner + IDX_W'(1);
        end
      end
      ST_HEADER: begin
        // Header is on the link; load the first data word behind it.
        src_pop_o   = grant_reg;
        packet_next = data_arr[idx_reg];
        cnt_next    = cnt_reg - N_PKTS_BITS'(1);
        state_next  = ST_DATA;
      end
      ST_DATA: begin
        if (cnt_reg != '0) begin
          src_pop_o   = grant_reg;
          packet_next = data_arr[idx_reg];
          cnt_next    = cnt_reg - N_PKTS_BITS'(1);
        end else begin
          state_next = ST_GAP;
          gap_next   = GAP_W'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (gap_reg == '0) begin
          state_next = ST_IDLE;
          grant_next = '0;
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_packet or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      gap_reg    <= '0;
      grant_reg  <= '0;
      idx_reg    <= '0;
      rr_ptr_reg <= '0;
      packet_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      gap_reg    <= gap_next;
      grant_reg  <= grant_next;
      idx_reg    <= idx_next;
      rr_ptr_reg <= rr_ptr_next;
      packet_reg <= packet_next;
      err_reg    <= err_next;
    end
  end

  assign packet_o = packet_reg;
  assign grant_o  = grant_reg;
  assign busy_o   = (state_reg != ST_IDLE);
  assign err_o    = err_reg;

endmodule

// File: tb/tb_packet_link_arbiter.sv
// Directed bench for packet_link_arbiter: FWFT source queues, a scoreboard of
// expected non-idle link words, and explicit timing/ownership checks.
module tb_packet_link_arbiter;

  localparam int NS = 4;
  localparam int PW = 16;
  localparam int NB = 5;

  logic             clk_packet = 1'b0;
  logic             reset;
  logic [NS-1:0]    src_req_i;
  logic [NS*NB-1:0] src_len_i;
  logic [NS-1:0]    src_dest_i;
  logic [NS*PW-1:0] src_data_i;
  logic [NS-1:0]    src_pop_o;
  logic             link_af_i;
  logic [PW-1:0]    packet_o;
  logic [NS-1:0]    grant_o;
  logic             busy_o;
  logic             err_o;

  packet_link_arbiter #(
    .NUM_SRC      (NS),
    .PACKET_WIDTH (PW),
    .N_PKTS_BITS  (NB),
    .GAP_CYCLES   (1)
  ) dut (
    .clk_packet (clk_packet),
    .reset      (reset),
    .src_req_i  (src_req_i),
    .src_len_i  (src_len_i),
    .src_dest_i (src_dest_i),
    .src_data_i (src_data_i),
    .src_pop_o  (src_pop_o),
    .link_af_i  (link_af_i),
    .packet_o   (packet_o),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk_packet = ~clk_packet;

  logic [PW-1:0] src_q [NS][$];
  logic [PW-1:0] exp_q [$];
  int            pop_cnt [NS];
  int            checks = 0;
  int            errors = 0;
  int            cycle  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] hdr(input int len, input int dest);
    return PW'(((len + 1) << 2) | (dest << 1) | 1);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NS; i++)
      src_data_i[i*PW +: PW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
  endtask

  task automatic set_len(input int s, input int len);
    src_len_i[s*NB +: NB] = NB'(len);
  endtask

  // One clock: advance popped sources, then score any non-idle link word.
  task automatic tick();
    logic [NS-1:0] pops;
    pops = src_pop_o;
    @(posedge clk_packet);
    #1;
    cycle++;
    for (int i = 0; i < NS; i++) begin
      if (pops[i]) begin
        pop_cnt[i]++;
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
    end
    drive_data();
    if (packet_o !== '0) begin
      if (exp_q.size() == 0) chk("unexpected_word", 32'(packet_o), 32'h0);
      else chk("link_word", 32'(packet_o), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while ((busy_o || exp_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'h0);
    chk({tag, "_idle"}, 32'(busy_o), 32'h0);
  endtask

  initial begin
    int h0, h1, p0, n;
    logic bprev;
    logic [NS-1:0] exp_order [5];

    reset      = 1'b1;
    src_req_i  = '0;
    src_len_i  = '0;
    src_dest_i = '0;
    src_data_i = '0;
    link_af_i  = 1'b0;
    for (int i = 0; i < NS; i++) pop_cnt[i] = 0;

    // 1: reset held three cycles
    repeat (3) tick();
    chk("rst_packet", 32'(packet_o), 32'h0);
    chk("rst_grant",  32'(grant_o),  32'h0);
    chk("rst_pop",    32'(src_pop_o), 32'h0);
    chk("rst_busy",   32'(busy_o),   32'h0);
    chk("rst_err",    32'(err_o),    32'h0);
    reset = 1'b0;
    tick();

    // 2: single source, len 3, dest 1
    src_q[0] = {16'h00A0, 16'h00B0, 16'h00C0};
    drive_data();
    exp_q = {16'h0013, 16'h00A0, 16'h00B0, 16'h00C0};
    set_len(0, 3);
    src_dest_i = 4'b0001;
    src_req_i  = 4'b0001;
    p0 = pop_cnt[0];
    tick();
    src_req_i = '0;
    chk("single_hdr_latency", 32'(packet_o), 32'h0013);
    chk("single_grant", 32'(grant_o), 32'h1);
    chk("single_busy", 32'(busy_o), 32'h1);
    repeat (3) tick();
    chk("single_last_data", 32'(packet_o), 32'h00C0);
    tick();
    chk("single_gap_zero", 32'(packet_o), 32'h0);
    chk("single_gap_busy", 32'(busy_o), 32'h1);
    tick();
    chk("single_back_idle", 32'(busy_o), 32'h0);
    chk("single_pop_count", 32'(pop_cnt[0] - p0), 32'd3);
    src_dest_i = '0;

    // 1b: reset asserted mid-DATA
    src_q[0] = {16'h0052, 16'h0054, 16'h0056, 16'h0058, 16'h005A};
    drive_data();
    exp_q = {hdr(5, 0), 16'h0052, 16'h0054};
    set_len(0, 5);
    src_req_i = 4'b0001;
    tick();
    src_req_i = '0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_packet", 32'(packet_o), 32'h0);
    chk("midrst_busy",   32'(busy_o),   32'h0);
    chk("midrst_grant",  32'(grant_o),  32'h0);
    chk("midrst_pop",    32'(src_pop_o), 32'h0);
    src_q[0].delete();
    drive_data();
    tick();
    tick();
    reset = 1'b0;
    chk("midrst_drained", 32'(exp_q.size()), 32'h0);
    tick();
    chk("midrst_stays_idle", 32'(busy_o), 32'h0);

    // 3: round-robin, all four sources with len 1
    src_q[0] = {16'h1000, 16'h1002};
    src_q[1] = {16'h2000};
    src_q[2] = {16'h3000};
    src_q[3] = {16'h4000};
    drive_data();
    exp_q = {hdr(1, 0), 16'h1000, hdr(1, 0), 16'h2000, hdr(1, 0), 16'h3000,
             hdr(1, 0), 16'h4000, hdr(1, 0), 16'h1002};
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < NS; i++) set_len(i, 1);
    src_req_i = 4'b1111;
    bprev = busy_o;
    n  = 0;
    h0 = 0;
    for (int t = 0; t < 60 && n < 5; t++) begin
      tick();
      if (busy_o && !bprev) begin
        chk($sformatf("rr_grant_%0d", n), 32'(grant_o), 32'(exp_order[n]));
        if (n > 0) chk($sformatf("rr_spacing_%0d", n), 32'(cycle - h0), 32'd4);
        h0 = cycle;
        n++;
        if (n == 5) src_req_i = '0;
      end
      bprev = busy_o;
    end
    chk("rr_grant_count", 32'(n), 32'd5);
    src_req_i = '0;
    wait_idle("rr", 20);

    // 4: almost-full blocks the start, not an ongoing transaction
    src_q[2] = {16'h0E20, 16'h0E22};
    drive_data();
    set_len(2, 2);
    link_af_i = 1'b1;
    src_req_i = 4'b0100;
    repeat (5) tick();
    chk("af_no_header", 32'(packet_o), 32'h0);
    chk("af_not_busy", 32'(busy_o), 32'h0);
    exp_q = {hdr(2, 0), 16'h0E20, 16'h0E22};
    p0 = pop_cnt[2];
    link_af_i = 1'b0;
    tick();
    src_req_i = '0;
    chk("af_header_next", 32'(packet_o), 32'(hdr(2, 0)));
    chk("af_grant", 32'(grant_o), 32'b0100);
    tick();
    link_af_i = 1'b1;
    wait_idle("af", 20);
    chk("af_pop_count", 32'(pop_cnt[2] - p0), 32'd2);
    link_af_i = 1'b0;

    // 5: malformed length (0) alongside a good source
    src_q[3] = {16'h0330, 16'h0332};
    drive_data();
    set_len(1, 0);
    set_len(3, 2);
    exp_q = {hdr(2, 0), 16'h0330, 16'h0332};
    p0 = pop_cnt[1];
    src_req_i = 4'b1010;
    tick();
    src_req_i = '0;
    chk("mal0_err", 32'(err_o), 32'h1);
    chk("mal0_grant", 32'(grant_o), 32'b1000);
    wait_idle("mal0", 20);
    chk("mal0_src1_pops", 32'(pop_cnt[1] - p0), 32'd0);
    chk("mal0_err_sticky", 32'(err_o), 32'h1);

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("mal_rst_err", 32'(err_o), 32'h0);

    // 5b: len MAX_LEN+1 with pointer at 0, so src1 would win if not masked
    src_q[3] = {16'h0340, 16'h0342};
    drive_data();
    set_len(1, 31);
    exp_q = {hdr(2, 0), 16'h0340, 16'h0342};
    p0 = pop_cnt[1];
    src_req_i = 4'b1010;
    tick();
    src_req_i = '0;
    chk("mal31_err", 32'(err_o), 32'h1);
    chk("mal31_grant", 32'(grant_o), 32'b1000);
    wait_idle("mal31", 20);
    chk("mal31_src1_pops", 32'(pop_cnt[1] - p0), 32'd0);
    chk("mal31_err_sticky", 32'(err_o), 32'h1);

    // 6: maximum length followed by a waiting source
    for (int k = 0; k < 30; k++) src_q[0].push_back(16'h0200 + 16'(k * 2));
    src_q[1] = {16'h0EEE};
    drive_data();
    set_len(0, 30);
    set_len(1, 1);
    exp_q = {hdr(30, 0)};
    for (int k = 0; k < 30; k++) exp_q.push_back(16'h0200 + 16'(k * 2));
    exp_q.push_back(hdr(1, 0));
    exp_q.push_back(16'h0EEE);
    p0 = pop_cnt[0];
    src_req_i = 4'b0011;
    tick();
    src_req_i = 4'b0010;
    chk("max_header", 32'(packet_o), 32'h007D);
    chk("max_grant", 32'(grant_o), 32'b0001);
    h0 = cycle;
    h1 = 0;
    bprev = busy_o;
    for (int t = 0; t < 60 && h1 == 0; t++) begin
      tick();
      if (busy_o && !bprev) begin
        h1 = cycle;
        src_req_i = '0;
        chk("max_next_grant", 32'(grant_o), 32'b0010);
      end
      bprev = busy_o;
    end
    src_req_i = '0;
    chk("max_next_spacing", 32'(h1 - h0), 32'd33);
    wait_idle("max", 20);
    chk("max_pop_count", 32'(pop_cnt[0] - p0), 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
